// File: rtl/ram_arbiter.sv
// Round-robin arbiter letting two requesters share one single-port RAM.
// Optional grant timeout abort is built when ARB_TIMEOUT_EN is defined.
module ram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          req_ren,
  input  logic [1:0]          req_wen,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_store,
  output logic [1:0]          req_wait,
  output logic [2*DATA_W-1:0] req_load,
  output logic                ram_ren,
  output logic                ram_wen,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_store,
  input  logic [DATA_W-1:0]   ram_load,
  input  logic [1:0]          ram_state,
  output logic                owner,
  output logic                err
);

  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;
  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_GRANT   = 1'b1;

  logic [0:0] r_state;
  logic       r_owner;

  logic [1:0] w_req;
  logic       w_grant;
  logic       w_own_req;
  logic       w_access;
  logic       w_error;
  logic       w_timeout;
  logic       w_abort;
  logic       w_done;

  assign w_req     = req_ren | req_wen;
  // Reset forces the outputs to their idle values even if the state was GRANT.
  assign w_grant   = (r_state == S_GRANT) & ~RST;
  assign w_own_req = w_req[r_owner];
  assign w_access  = w_grant & (ram_state == RS_ACCESS);
  assign w_error   = w_grant & (ram_state == RS_ERROR);
  assign w_abort   = w_error | w_timeout;
  assign w_done    = w_access | w_abort;

`ifdef ARB_TIMEOUT_EN
  logic [3:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= 4'd0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // A completion arriving on the limit cycle beats the abort.
  assign w_timeout = w_grant & (r_cnt == 4'(TIMEOUT - 1)) & (ram_state != RS_ACCESS);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_owner <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_req) begin
            r_state <= S_GRANT;
            r_owner <= (w_req == 2'b11) ? ~r_owner : w_req[1];
          end
        end
        default: begin
          if (w_done | ~w_own_req) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Write wins when a requester raises both enables.
  assign ram_wen   = w_grant & req_wen[r_owner];
  assign ram_ren   = w_grant & req_ren[r_owner] & ~req_wen[r_owner];
  assign ram_addr  = w_grant ? req_addr[r_owner*ADDR_W +: ADDR_W] : '0;
  assign ram_store = w_grant ? req_store[r_owner*DATA_W +: DATA_W] : '0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic w_mine;
      assign w_mine = (r_owner == 1'(gi));
      assign req_wait[gi] = w_req[gi] & ~(w_done & w_mine);
      assign req_load[gi*DATA_W +: DATA_W] = (w_access & w_mine) ? ram_load : '0;
    end
  endgenerate

  assign owner = r_owner;
  assign err   = w_abort;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter (grant timeout of 3 cycles;
// timeout expectations follow whether ARB_TIMEOUT_EN is defined).
module tb_ram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [1:0]    req_ren = '0;
  logic [1:0]    req_wen = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_store = '0;
  logic [1:0]    req_wait;
  logic [2*DW-1:0] req_load;
  logic          ram_ren;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_store;
  logic [DW-1:0] ram_load = '0;
  logic [1:0]    ram_state = 2'b00;
  logic          owner;
  logic          err;

  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;
  localparam logic [1:0] ERROR  = 2'b11;

  int n_cmp = 0;
  int n_err = 0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(3)) dut (
    .CLK(CLK), .RST(RST),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_load(req_load),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_store(ram_store),
    .ram_load(ram_load), .ram_state(ram_state),
    .owner(owner), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    int e;
    // Reset state
    tick; tick;
    chk("rst_owner", 64'(owner), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ren", 64'(ram_ren), 64'd0);
    chk("rst_addr", 64'(ram_addr), 64'd0);
    chk("rst_load", req_load, 64'd0);
    req_ren = 2'b10;
    settle;
    chk("rst_wait_follows_req", 64'(req_wait), 64'b10);
    chk("rst_ren_held", 64'(ram_ren), 64'd0);
    req_ren = 2'b00;
    RST = 1'b0;
    tick;

    // Single read from requester 0
    req_ren = 2'b01;
    req_addr[31:0] = 32'h100;
    settle;
    chk("rd_idle_ren", 64'(ram_ren), 64'd0);
    chk("rd_idle_wait", 64'(req_wait), 64'b01);
    tick;
    ram_state = ACCESS;
    ram_load = 32'hDEADBEEF;
    settle;
    chk("rd_owner", 64'(owner), 64'd0);
    chk("rd_ren", 64'(ram_ren), 64'd1);
    chk("rd_addr", 64'(ram_addr), 64'h100);
    chk("rd_load", req_load, 64'h0000_0000_DEAD_BEEF);
    chk("rd_wait", 64'(req_wait), 64'b00);
    tick;
    req_ren = 2'b00;
    ram_state = FREE;
    settle;
    chk("rd_back_idle", 64'(ram_ren), 64'd0);
    $display("txn single read addr=100 load=%0h", 32'hDEADBEEF);

    // Reset in the middle of a grant
    req_ren = 2'b01;
    req_addr[31:0] = 32'h40;
    tick;
    chk("mid_grant_ren", 64'(ram_ren), 64'd1);
    chk("mid_grant_addr", 64'(ram_addr), 64'h40);
    RST = 1'b1;
    tick;
    RST = 1'b0;
    settle;
    chk("mid_rst_ren", 64'(ram_ren), 64'd0);
    chk("mid_rst_owner", 64'(owner), 64'd1);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_wait", 64'(req_wait), 64'b01);
    tick;
    chk("rearb_owner", 64'(owner), 64'd0);
    chk("rearb_ren", 64'(ram_ren), 64'd1);
    // Owner abandons: enables fall the same cycle, no error
    req_ren = 2'b00;
    settle;
    chk("abandon_ren", 64'(ram_ren), 64'd0);
    chk("abandon_err", 64'(err), 64'd0);
    tick;
    $display("txn reset mid-grant then abandon");

    // RAM ERROR on a requester 1 read while requester 0 waits
    req_ren = 2'b10;
    req_addr[63:32] = 32'h20;
    tick;
    chk("er_owner", 64'(owner), 64'd1);
    chk("er_addr", 64'(ram_addr), 64'h20);
    req_wen = 2'b01;
    req_addr[31:0] = 32'h8;
    req_store[31:0] = 32'h1234;
    ram_state = ERROR;
    ram_load = 32'hFFFFFFFF;
    settle;
    chk("er_err", 64'(err), 64'd1);
    chk("er_wait", 64'(req_wait), 64'b01);
    chk("er_load", req_load, 64'd0);
    chk("er_wen", 64'(ram_wen), 64'd0);
    tick;
    req_addr[63:32] = 32'hC;
    ram_state = FREE;
    settle;
    chk("er_pulse_end", 64'(err), 64'd0);
    $display("txn error abort on requester 1");

    // Contention: strict alternation starting with requester 0
    for (int g = 0; g < 4; g++) begin
      e = g % 2;
      ram_state = FREE;
      settle;
      chk("ct_idle_ren", 64'(ram_ren | ram_wen), 64'd0);
      chk("ct_idle_wait", 64'(req_wait), 64'b11);
      tick;
      for (int c = 0; c < 3; c++) begin
        ram_state = (c < 2) ? BUSY : ACCESS;
        ram_load = 32'hA000_0000 + 32'(g);
        settle;
        chk("ct_owner", 64'(owner), 64'(e));
        chk("ct_wen", 64'(ram_wen), (e == 0) ? 64'd1 : 64'd0);
        chk("ct_ren", 64'(ram_ren), (e == 1) ? 64'd1 : 64'd0);
        chk("ct_addr", 64'(ram_addr), (e == 0) ? 64'h8 : 64'hC);
        chk("ct_store", 64'(ram_store), (e == 0) ? 64'h1234 : 64'h0);
        if (c < 2) begin
          chk("ct_wait_busy", 64'(req_wait), 64'b11);
          chk("ct_load_busy", req_load, 64'd0);
        end else begin
          chk("ct_wait_done", 64'(req_wait), (e == 0) ? 64'b10 : 64'b01);
          chk("ct_load_done", req_load,
              (e == 0) ? {32'h0, 32'hA000_0000 + 32'(g)} : {32'hA000_0000 + 32'(g), 32'h0});
        end
        tick;
      end
      $display("txn contention grant %0d to requester %0d", g, e);
    end

    // Requester 1 raises ren and wen together: treated as a write
    req_ren = 2'b10;
    req_wen = 2'b10;
    req_store[63:32] = 32'h5678;
    ram_state = FREE;
    tick;
    ram_state = BUSY;
    settle;
    chk("rw_owner", 64'(owner), 64'd1);
    chk("rw_wen", 64'(ram_wen), 64'd1);
    chk("rw_ren", 64'(ram_ren), 64'd0);
    chk("rw_store", 64'(ram_store), 64'h5678);
    chk("rw_wait_busy", 64'(req_wait), 64'b10);
    ram_state = ACCESS;
    settle;
    chk("rw_wait_done", 64'(req_wait), 64'b00);
    tick;
    req_ren = 2'b00;
    req_wen = 2'b00;
    ram_state = FREE;
    $display("txn ren+wen write from requester 1");

    // RAM stuck BUSY
    req_ren = 2'b01;
    req_addr[31:0] = 32'h50;
    tick;
    ram_state = BUSY;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 3; c++) begin
      settle;
      chk("to_err", 64'(err), (c == 2) ? 64'd1 : 64'd0);
      chk("to_wait", 64'(req_wait), (c == 2) ? 64'b00 : 64'b01);
      chk("to_load", req_load, 64'd0);
      tick;
    end
    settle;
    chk("to_idle_ren", 64'(ram_ren), 64'd0);
    $display("txn timeout abort on third grant cycle");
    tick;
    for (int c = 0; c < 3; c++) begin
      ram_state = (c < 2) ? BUSY : ACCESS;
      ram_load = 32'h55;
      settle;
      chk("tl_owner", 64'(owner), 64'd0);
      chk("tl_err", 64'(err), 64'd0);
      chk("tl_wait", 64'(req_wait), (c == 2) ? 64'b00 : 64'b01);
      chk("tl_load", req_load, (c == 2) ? 64'h55 : 64'h0);
      tick;
    end
    $display("txn access on limit cycle completes normally");
`else
    for (int c = 0; c < 20; c++) begin
      settle;
      tick;
    end
    settle;
    chk("nt_ren", 64'(ram_ren), 64'd1);
    chk("nt_err", 64'(err), 64'd0);
    chk("nt_wait", 64'(req_wait), 64'b01);
    chk("nt_addr", 64'(ram_addr), 64'h50);
    ram_state = ACCESS;
    ram_load = 32'h77;
    settle;
    chk("nt_load", req_load, 64'h77);
    tick;
    $display("txn grant held 20 cycles without timeout");
`endif
    req_ren = 2'b00;
    ram_state = FREE;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter sharing the single-port RAM between processor-side memory ports (core 0/core 1, or icache/dcache).
- Sits between the processor memory requests and the RAM's ram* port, under the testbench-control mux in the system top.
- Grants one requester at a time, round-robin, and drives its request onto the RAM.
- Returns load data and drops wait to the owner on completion.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, load/store data width.
- TIMEOUT, 15, cycles an owner may hold a grant without RAM completion before a forced abort (ARB_TIMEOUT_EN only); 4-bit counter, legal range 1..15.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- req_ren  in  2  per-requester read request, bit i = requester i.
- req_wen  in  2  per-requester write request.
- req_addr  in  2xADDR_W  per-requester address.
- req_store  in  2xDATA_W  per-requester write data.
- req_wait  out  2  high = requester i's access not complete.
- req_load  out  2xDATA_W  read data to requester i.
- ram_ren  out  1  RAM read enable.
- ram_wen  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_store  out  DATA_W  RAM write data.
- ram_load  in  DATA_W  RAM read data.
- ram_state  in  2  00 FREE, 01 BUSY, 10 ACCESS (done this cycle), 11 ERROR.
- owner  out  1  registered current/last grant index.
- err  out  1  one-cycle pulse on ERROR abort or timeout abort.

Behaviour:
- Request: requester i requests when req_ren[i] | req_wen[i]. If both are set, it is a write; ram_ren is forced 0.
- FSM states:
  - IDLE: no grant; ram_ren = ram_wen = 0; ram_addr and ram_store driven 0.
  - GRANT: owner's live inputs muxed combinationally onto the ram_* outputs.
- IDLE -> GRANT:
  - On any request, registered.
  - One request pending: that requester wins.
  - Both pending: the requester != owner wins (round-robin).
  - After reset, owner = 1, so requester 0 wins the first tie.
- GRANT, ram_state == ACCESS:
  - req_wait[owner] = 0 this cycle.
  - req_load[owner] = ram_load (valid on reads only).
  - Next state IDLE.
- GRANT, ram_state == ERROR:
  - req_wait[owner] = 0, req_load[owner] = 0.
  - err = 1 for this cycle; next state IDLE.
- GRANT, owner drops both ren and wen:
  - Abandon; next state IDLE, no err.
  - ram enables go 0 the same cycle (combinational mux).
- GRANT, FREE or BUSY: stay in GRANT.
- req_wait[i] = request_i & ~(GRANT & owner == i & ram_state in {ACCESS, ERROR}).
  - A non-requesting port has wait = 0.
  - A non-owner requester waits.
- req_load[i] = 0 unless completing.
- Latency:
  - Request seen in IDLE at cycle N -> ram_* valid at N+1.
  - Earliest completion at N+1 (ACCESS in the grant cycle).
  - At least one IDLE cycle between transactions, so each transaction takes 2 cycles minimum.
- Fairness: with both requesting continuously, grants strictly alternate 0,1,0,1.
- Owner changes address mid-grant: the new address passes through; the RAM is responsible.
- Reset (any cycle, including mid-GRANT):
  - state IDLE, owner = 1, err = 0, timeout counter = 0.
  - All ram_* outputs 0; req_wait = request bits; req_load = 0.
  - Next cycle arbitrates fresh.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - 4-bit counter cleared on entering GRANT; increments each GRANT cycle without ACCESS/ERROR.
  - When the count reaches TIMEOUT and ram_state != ACCESS: abort like ERROR (wait 0, load 0, err pulse, next IDLE).
  - ACCESS on the same cycle as the limit wins (normal completion).
- Undefined: no counter; GRANT holds indefinitely until ACCESS, ERROR or the requester drops.

Test Plan:
- Reset mid-transaction: RST high during GRANT with req0 reading 0x40 -> next cycle IDLE, ram_ren = 0, owner = 1, err = 0.
- Single read: req_ren = 01, addr 0x100; RAM returns ACCESS on the first grant cycle with ram_load 0xDEADBEEF -> ram_addr = 0x100 at N+1, req_load[0] = 0xDEADBEEF with req_wait[0] = 0 the same cycle, then IDLE.
- Contention: both requesting continuously (req0 write 0x8 data 0x1234, req1 read 0xC), RAM BUSY 2 cycles then ACCESS -> grant order 0,1,0,1; req_wait[1] stays 1 throughout req0's grant; ram_ren = 0 during 0's writes.
- ren + wen together from req1 -> ram_wen = 1, ram_ren = 0.
- RAM ERROR on a req1 read -> err pulses 1 cycle, req_wait[1] = 0, req_load[1] = 0, next grant goes to req0 if pending.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT = 3), RAM stuck BUSY:
  - Abort on the 3rd grant cycle with err = 1.
  - Variant with ACCESS on exactly the 3rd cycle -> normal completion, err = 0.
  - Without the macro -> still in GRANT after 20 cycles.
